memory_arbiter: RTL
===================

# memory_arbiter

Two-requester arbiter that shares the single core-side memory port (valid/instr/addr/wdata/wstrb/rdata/ready) between two bus masters, e.g. CPU and a debug/DMA master. It sits between the requesters and the SoC address decoder (bram, print, clint, clic) and holds one outstanding transaction at a time. Round-robin arbitration with an optional watchdog that completes transactions to unmapped addresses, which would otherwise never see ready.

## Interface
Parameters:
- TIMEOUT, 1024: watchdog limit in cycles. Range 2..65535, held in a 16-bit counter.

Ports (n = 0, 1):
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- reqn_valid  in  1  request from requester n; held with its fields stable until reqn_ready
- reqn_instr  in  1  instruction-fetch qualifier
- reqn_addr  in  32  byte address
- reqn_wdata  in  32  write data
- reqn_wstrb  in  4  byte strobes; 0 = read
- reqn_rdata  out  32  read data, valid while reqn_ready=1
- reqn_ready  out  1  one-cycle completion strobe to requester n
- memory_valid  out  1  request to decoder
- memory_instr  out  1  forwarded reqn_instr of granted requester
- memory_addr  out  32  forwarded address
- memory_wdata  out  32  forwarded write data
- memory_wstrb  out  4  forwarded strobes
- memory_rdata  in  32  read data from decoder
- memory_ready  in  1  completion from decoder
- timeout_err  out  1  one-cycle pulse on watchdog completion

## Operation
- States: IDLE, GRANT0, GRANT1. Register last (last served requester), reset to 1 so req0 wins first.
- IDLE: memory_valid=0, all memory_* forwarding fields 0. Only req0_valid -> GRANT0. Only req1_valid -> GRANT1. Both -> grant the requester not equal to last.
- GRANTn: memory_valid=reqn_valid; instr/addr/wdata/wstrb forwarded combinationally from requester n. reqn_rdata=memory_rdata and reqn_ready=memory_ready. The other requester sees ready=0, rdata=0.
- On memory_ready in GRANTn:
  - last <= n.
  - If the other requester is valid: go directly to GRANT(other) (round-robin handoff, no idle cycle).
  - Else, if reqn_valid is re-asserted the next cycle: it is arbitrated from IDLE.
  - Else: -> IDLE.
- A requester dropping valid while granted is illegal. The arbiter stays granted and the bench flags it as an assertion failure.
- memory_ready while IDLE is ignored and is not forwarded to either requester.

## Timing
- Reset values: memory_valid=0, memory_* = 0, req0_ready=req1_ready=0, req0_rdata=req1_rdata=0, timeout_err=0, state=IDLE, last=1, watchdog count=0.
- Arbitration latency: one cycle from reqn_valid rising in IDLE to memory_valid=1.
- Handoff: zero idle cycles when the other requester is pending at the ready cycle.
- Ready path is combinational. memory_ready in cycle t gives reqn_ready in cycle t.
- Reset asserted mid-transaction: state returns to IDLE immediately and asynchronously, and all outputs drop to 0. A decoder response arriving afterwards is ignored.

## Configuration
- Macro MEMORY_ARBITER_TIMEOUT_EN.
- Defined:
  - The watchdog counter clears on every grant entry, including handoff, and increments each cycle in GRANTn without memory_ready.
  - When the count reaches TIMEOUT-1 with no ready, the arbiter completes the transaction that cycle: reqn_ready=1, reqn_rdata=0, timeout_err=1, memory_valid=0.
  - It then transitions exactly as on a normal ready.
  - memory_ready arriving in the same cycle wins: normal completion, no error.
- Not defined: no counter is synthesized, timeout_err is tied 0, and a transaction waits indefinitely.

## Structure
- Shared configure package holds:
  - the state typedef: enum logic [1:0] with IDLE, GRANT0, GRANT1;
  - the constant memory_timeout_cycles, which sets the TIMEOUT default.
- One sub-module, memory_timeout:
  - a counter with clear and enable inputs and an expire output;
  - instantiated only under MEMORY_ARBITER_TIMEOUT_EN.

## Test plan
- Single requester: req0 reads 0x00000100 and the decoder returns 0xDEADBEEF after 3 cycles. Expect memory_valid 1 cycle after req0_valid, req0_ready pulse with rdata 0xDEADBEEF, req1_ready never asserted.
- Simultaneous requests: req0 and req1 both valid from reset. Expect grants in the order req0, req1, req0, req1 with no IDLE cycle between handoffs, and each ready routed only to the granted requester.
- Write forwarding: req1 writes wdata 0x12345678 with wstrb 0x3 to 0x02000004. Expect memory_addr, wdata and wstrb equal to req1's fields while GRANT1, and memory_instr=0.
- Timeout (macro on, TIMEOUT=16): req0 targets an unmapped address. Expect req0_ready and timeout_err at cycle 16 after grant with rdata 0. A later spurious memory_ready in IDLE produces no requester ready.
- Reset mid-transaction: drop reset while in GRANT1. Expect all outputs 0 immediately. After release, with both requesters valid, req0 is granted first.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared configuration for the two-requester memory arbiter:
// arbiter state encoding and the default watchdog limit.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Default cycles a granted transaction may wait before the watchdog completes it.
    localparam int unsigned memory_timeout_cycles = 1024;

endpackage

// File: rtl/memory_timeout.sv
// Watchdog counter for the memory arbiter. Counts enabled cycles since the
// last clear and flags expiry on the cycle the count reaches LIMIT-1.
module memory_timeout
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = memory_timeout_cycles
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [15:0] count;

    // Cycle counter; clear wins over enable so a fresh grant always starts at 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 16'd1;
    end

    assign expire = enable && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one core-side memory port between two masters.
// One transaction outstanding at a time; the grant hands off directly to a
// waiting requester without an idle cycle.
// Optional watchdog (macro MEMORY_ARBITER_TIMEOUT_EN) completes transactions
// that never see memory_ready, returning rdata 0 and pulsing timeout_err.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = memory_timeout_cycles
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_instr,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_wstrb,
    output logic [31:0] req0_rdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_instr,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_wstrb,
    output logic [31:0] req1_rdata,
    output logic        req1_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic        timeout_err
);

    state_t state, state_next;
    logic   last, last_next;    // 1 = requester 1 was served most recently
    logic   granted;
    logic   done;               // current transaction completes this cycle
    logic   expire;

    assign granted = (state != IDLE);
    assign done    = granted && (memory_ready || expire);

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    memory_timeout #(.LIMIT(TIMEOUT)) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (!granted || done),
        .enable (granted && !memory_ready),
        .expire (expire)
    );
`else
    // Without the watchdog a transaction waits for the decoder indefinitely.
    logic unused_timeout;
    assign expire         = 1'b0;
    assign unused_timeout = ^16'(TIMEOUT);
`endif

    // State and round-robin history registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    // Next-state: arbitrate from IDLE, hand off or release on completion.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last))
                    state_next = GRANT0;
                else if (req1_valid)
                    state_next = GRANT1;
            end
            GRANT0: begin
                if (done) begin
                    last_next  = 1'b0;
                    state_next = req1_valid ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (done) begin
                    last_next  = 1'b1;
                    state_next = req0_valid ? GRANT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Forwarding mux: granted requester drives the memory port, ready/rdata
    // route back only to it; a watchdog completion withdraws memory_valid.
    always_comb begin
        memory_valid = 1'b0;
        memory_instr = 1'b0;
        memory_addr  = '0;
        memory_wdata = '0;
        memory_wstrb = '0;
        req0_ready   = 1'b0;
        req0_rdata   = '0;
        req1_ready   = 1'b0;
        req1_rdata   = '0;
        timeout_err  = expire;
        case (state)
            GRANT0: begin
                memory_valid = req0_valid && !expire;
                memory_instr = req0_instr;
                memory_addr  = req0_addr;
                memory_wdata = req0_wdata;
                memory_wstrb = req0_wstrb;
                req0_ready   = memory_ready || expire;
                req0_rdata   = expire ? '0 : memory_rdata;
            end
            GRANT1: begin
                memory_valid = req1_valid && !expire;
                memory_instr = req1_instr;
                memory_addr  = req1_addr;
                memory_wdata = req1_wdata;
                memory_wstrb = req1_wstrb;
                req1_ready   = memory_ready || expire;
                req1_rdata   = expire ? '0 : memory_rdata;
            end
            default: ;
        endcase
    end

endmodule
